// File: rtl/q_in_debouncer.sv
// Input conditioner for the asynchronous q status line: synchroniser, glitch filter,
// registered level for the PIO in_port, rise/fall strobes and a saturating rise counter.
module q_in_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int RESET_LEVEL     = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_in,
  input  logic       enable,
  input  logic       clr_events,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] event_count,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam logic             RST_LVL   = (RESET_LEVEL != 0);
  localparam state_t           RST_STATE = RST_LVL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_d, fall_d;
  logic                   level_d, busy_d;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the number of consecutive disagreeing samples already seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      case (state_q)
        CHECK_HI: state_d = STABLE_LO;
        CHECK_LO: state_d = STABLE_HI;
        default:  state_d = state_q;
      endcase
    end else begin
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            if (IMMEDIATE) begin
              state_d = STABLE_HI;
              rise_d  = 1'b1;
            end else begin
              state_d = CHECK_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (IMMEDIATE) begin
              state_d = STABLE_LO;
              fall_d  = 1'b1;
            end else begin
              state_d = CHECK_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RST_STATE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered copies of the next-state decode so nothing is combinational.
  assign level_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
  assign busy_d  = (state_d == CHECK_HI) || (state_d == CHECK_LO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_out  <= RST_LVL;
      busy       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      level_out  <= level_d;
      busy       <= busy_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  // A clear coinciding with an accepted rise counts that rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_count <= 8'd0;
    end else if (clr_events) begin
      event_count <= rise_d ? 8'd1 : 8'd0;
    end else if (rise_d && (event_count != 8'hFF)) begin
      event_count <= event_count + 8'd1;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_q_in_debouncer.sv
// Directed bench for q_in_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_q_in_debouncer;

  logic       clk;
  logic       reset_n;
  logic       raw_in;
  logic       enable;
  logic       clr_events;
  logic       level_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] event_count;
  logic       busy;
  logic [1:0] state_dbg;

  int checks;
  int errors;
  int n_rise;
  int n_fall;

  q_in_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .RESET_LEVEL    (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .enable     (enable),
    .clr_events (clr_events),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_count(event_count),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then tally any strobes seen after it.
  task automatic tick();
    @(posedge clk);
    #1;
    n_rise += int'(rise_pulse);
    n_fall += int'(fall_pulse);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle(input logic v);
    raw_in = v;
    ticks(8);
  endtask

  initial begin
    checks = 0; errors = 0; n_rise = 0; n_fall = 0;
    reset_n = 1'b0; raw_in = 1'b0; enable = 1'b1; clr_events = 1'b0;

    // 1: reset values, then idle low
    ticks(3);
    chk("reset_level", level_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rise", rise_pulse, 0);
    chk("reset_fall", fall_pulse, 0);
    chk("reset_count", event_count, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_level", level_out, 0);
    end
    chk("idle_rises", n_rise, 0);
    chk("idle_falls", n_fall, 0);
    chk("idle_count", event_count, 0);

    // 2: clean rise; raw set before edge E, accepted on E+5
    raw_in = 1'b1;
    tick(); chk("rise_busy_e0", busy, 0);
    tick(); chk("rise_busy_e1", busy, 0);
    tick(); chk("rise_busy_e2", busy, 1);
    tick(); chk("rise_busy_e3", busy, 1);
    tick(); chk("rise_busy_e4", busy, 1); chk("rise_level_e4", level_out, 0);
    tick();
    chk("rise_level_e5", level_out, 1);
    chk("rise_pulse_e5", rise_pulse, 1);
    chk("rise_busy_e5", busy, 0);
    chk("rise_count", event_count, 1);
    tick();
    chk("rise_pulse_e6", rise_pulse, 0);
    chk("rise_total", n_rise, 1);

    // 3a: 3-cycle glitch is rejected
    settle(1'b0);
    chk("fall_total", n_fall, 1);
    chk("low_level", level_out, 0);
    n_rise = 0; n_fall = 0;
    raw_in = 1'b1; ticks(3);
    raw_in = 1'b0; ticks(10);
    chk("glitch_level", level_out, 0);
    chk("glitch_rises", n_rise, 0);
    chk("glitch_falls", n_fall, 0);
    chk("glitch_count", event_count, 1);

    // 3b: 4-cycle pulse is just long enough
    raw_in = 1'b1; ticks(4);
    raw_in = 1'b0;
    tick(); chk("pulse4_level_t1", level_out, 0);
    tick(); chk("pulse4_rise", rise_pulse, 1); chk("pulse4_level_t2", level_out, 1);
    ticks(3); chk("pulse4_level_t5", level_out, 1); chk("pulse4_nofall", n_fall, 0);
    tick(); chk("pulse4_fall", fall_pulse, 1); chk("pulse4_level_t6", level_out, 0);
    tick(); chk("pulse4_fall_off", fall_pulse, 0);
    chk("pulse4_rises", n_rise, 1);
    chk("pulse4_count", event_count, 2);

    // 4: saturation, then clear coinciding with a rise
    for (int i = 0; i < 260; i++) begin
      raw_in = 1'b1; ticks(6);
      raw_in = 1'b0; ticks(6);
    end
    chk("sat_count", event_count, 255);
    raw_in = 1'b1; ticks(5);
    clr_events = 1'b1;
    tick();
    clr_events = 1'b0;
    chk("clr_rise_pulse", rise_pulse, 1);
    chk("clr_rise_count", event_count, 1);
    tick(); chk("clr_hold_count", event_count, 1);
    clr_events = 1'b1; tick(); clr_events = 1'b0;
    chk("clr_only_count", event_count, 0);

    // 5: enable dropped for one cycle while cnt=2
    settle(1'b0);
    n_rise = 0;
    raw_in = 1'b1;
    ticks(4); chk("en_busy_cnt2", busy, 1);
    enable = 1'b0;
    tick(); chk("en_busy_off", busy, 0);
    enable = 1'b1;
    tick(); chk("en_orig_rise", rise_pulse, 0); chk("en_orig_level", level_out, 0);
    chk("en_busy_restart", busy, 1);
    ticks(2); chk("en_level_t8", level_out, 0);
    tick(); chk("en_level_t9", level_out, 1); chk("en_rise_t9", rise_pulse, 1);
    chk("en_rises", n_rise, 1);

    // 6: reset in the middle of CHECK_HI
    settle(1'b0);
    n_rise = 0;
    raw_in = 1'b1;
    ticks(3); chk("rst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_level", level_out, 0);
    chk("rst_count", event_count, 0);
    chk("rst_rise", rise_pulse, 0);
    ticks(2);
    reset_n = 1'b1;
    ticks(5);
    chk("rst_level_t5", level_out, 0);
    chk("rst_norise_early", n_rise, 0);
    tick();
    chk("rst_level_t6", level_out, 1);
    chk("rst_rise_t6", rise_pulse, 1);
    chk("rst_count_after", event_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
